// File: rtl/trace_buf.sv
// trace_buf: triggered / single-fill trace capture buffer with oldest-first
// ready/valid readout of the captured window.
module trace_buf #(
   parameter int P_CH = 6,
   parameter int P_W = 24,
   parameter int P_DEPTH = 16,
   localparam int AW = $clog2(P_DEPTH),
   localparam int CW = AW + 1,
   localparam int DW = P_CH * P_W
) (
   input  logic          iw_clk,
   input  logic          iw_rst,
   input  logic [DW-1:0] iw_data,
   input  logic          iw_valid,
   input  logic          iw_mode,
   input  logic          iw_arm,
   input  logic          iw_trig,
   input  logic [AW-1:0] iw_post,
   input  logic          iw_abort,
   input  logic          iw_rd_start,
   input  logic          iw_ready,
   output logic          or_valid,
   output logic [DW-1:0] or_data,
   output logic          or_last,
   output logic [2:0]    or_state,
   output logic [AW:0]   or_count
);
   typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, POST = 3'd2, DONE = 3'd3, READ = 3'd4} state_t;
   state_t state, state_nx;
   logic [DW-1:0] mem [P_DEPTH];
   logic [AW-1:0] wp, rp, rem;
   logic [CW-1:0] left;
   logic mode, wr, arm_go, trig_go, rd_go, load, rd_end, fill_end, post_end;
   assign or_state = state;
   always_comb begin
      wr = iw_rst && !iw_abort && iw_valid && (state == ARMED || state == POST);
      arm_go = !iw_abort && iw_arm && (state == IDLE || state == DONE);
      trig_go = !iw_abort && iw_trig && !mode && state == ARMED;
      rd_go = !iw_abort && !iw_arm && iw_rd_start && state == DONE && or_count != '0;
      load = state == READ && (!or_valid || (iw_ready && !or_last));
      rd_end = state == READ && or_valid && iw_ready && or_last;
      fill_end = wr && mode && state == ARMED && or_count == CW'(P_DEPTH - 1);
      post_end = wr && state == POST && rem == AW'(1);
      state_nx = state;
      if (iw_abort) state_nx = IDLE;
      else if (arm_go) state_nx = ARMED;
      else if (trig_go) state_nx = iw_post == '0 ? DONE : POST;
      else if (fill_end || post_end) state_nx = DONE;
      else if (rd_go) state_nx = READ;
      else if (rd_end) state_nx = IDLE;
   end
   always_ff @(posedge iw_clk)
      if (!iw_rst) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge iw_clk)
      if (wr) mem[wp] <= iw_data;
   always_ff @(posedge iw_clk) begin
      if (!iw_rst) begin
         wp <= '0;
         rp <= '0;
         rem <= '0;
         left <= '0;
         mode <= 1'b0;
         or_count <= '0;
         or_valid <= 1'b0;
         or_last <= 1'b0;
         or_data <= '0;
      end else begin
         if (arm_go) begin
            wp <= '0;
            or_count <= '0;
            mode <= iw_mode;
         end else if (wr) begin
            wp <= wp + 1'b1;
            if (or_count != CW'(P_DEPTH)) or_count <= or_count + 1'b1;
         end
         if (trig_go) rem <= iw_post;
         else if (wr && state == POST) rem <= rem - 1'b1;
         // a full buffer has wrapped, so its oldest entry sits at the write pointer
         if (rd_go) begin
            rp <= or_count == CW'(P_DEPTH) ? wp : '0;
            left <= or_count;
         end else if (load) begin
            or_data <= mem[rp];
            rp <= rp + 1'b1;
            left <= left - 1'b1;
            or_valid <= 1'b1;
            or_last <= left == CW'(1);
         end
         if (iw_abort || rd_end) begin
            or_valid <= 1'b0;
            or_last <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_trace_buf.sv
// tb_trace_buf: randomized and directed checks of trace_buf against a
// queue-based model of the captured window (P_CH=2, P_W=8, P_DEPTH=16).
module tb_trace_buf;
   localparam int D = 16;
   localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DONE = 3, S_READ = 4;
   logic iw_clk = 0, iw_rst = 0, iw_valid = 0, iw_mode = 0, iw_arm = 0, iw_trig = 0;
   logic iw_abort = 0, iw_rd_start = 0, iw_ready = 1;
   logic [15:0] iw_data = '0;
   logic [3:0] iw_post = '0;
   logic or_valid, or_last;
   logic [15:0] or_data;
   logic [2:0] or_state;
   logic [4:0] or_count;
   int checks = 0, failures = 0;
   int ms = S_IDLE, mrem = 0;
   bit mmode = 0;
   logic [15:0] q[$], got[$];

   trace_buf #(.P_CH(2), .P_W(8), .P_DEPTH(D)) dut (
      .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_data(iw_data), .iw_valid(iw_valid),
      .iw_mode(iw_mode), .iw_arm(iw_arm), .iw_trig(iw_trig), .iw_post(iw_post),
      .iw_abort(iw_abort), .iw_rd_start(iw_rd_start), .iw_ready(iw_ready),
      .or_valid(or_valid), .or_data(or_data), .or_last(or_last),
      .or_state(or_state), .or_count(or_count));

   always #5 iw_clk = ~iw_clk;

   function automatic logic [15:0] pat(input int i);
      logic [7:0] b = 8'(i);
      return {b, b ^ 8'h5A};
   endfunction

   task automatic cyc();
      @(posedge iw_clk);
      #1;
   endtask

   // The model keeps only the newest D samples; the stored count is its size.
   task automatic push(input logic [15:0] d);
      q.push_back(d);
      if (q.size() > D) q.delete(0);
   endtask

   task automatic tick();
      if (!iw_rst) begin
         ms = S_IDLE;
         q.delete();
      end else if (iw_abort) ms = S_IDLE;
      else if ((ms == S_IDLE || ms == S_DONE) && iw_arm) begin
         ms = S_ARMED;
         q.delete();
         mmode = iw_mode;
      end else if (ms == S_ARMED) begin
         if (iw_valid) push(iw_data);
         if (mmode && q.size() == D) ms = S_DONE;
         else if (!mmode && iw_trig) begin
            mrem = int'(iw_post);
            ms = mrem == 0 ? S_DONE : S_POST;
         end
      end else if (ms == S_POST && iw_valid) begin
         push(iw_data);
         mrem--;
         if (mrem == 0) ms = S_DONE;
      end else if (ms == S_DONE && iw_rd_start && q.size() != 0) ms = S_READ;
      cyc();
   endtask

   task automatic sample(input logic [15:0] d, input bit v, input bit t, input logic [3:0] p);
      iw_data = d; iw_valid = v; iw_trig = t; iw_post = p;
      tick();
      iw_valid = 0; iw_trig = 0;
   endtask

   task automatic arm(input bit m);
      iw_mode = m; iw_arm = 1;
      tick();
      iw_arm = 0;
   endtask

   task automatic clear();
      iw_abort = 1;
      tick();
      iw_abort = 0;
   endtask

   // Collects transferred entries into got; rp selects ready: 0 always, 1 = 1,0,0 repeating, 2 random.
   task automatic readout(input int rp, output int lat, output int last_pos, output int nlast,
                          output int unstable);
      logic [16:0] held = '0;
      bit stall = 0;
      got.delete();
      lat = -1; last_pos = -1; nlast = 0; unstable = 0;
      iw_rd_start = 1;
      tick();
      iw_rd_start = 0;
      for (int c = 0; c < 300; c++) begin
         iw_ready = rp == 0 ? 1'b1 : rp == 1 ? (c % 3 == 0) : 1'($urandom % 2);
         if (stall && (!or_valid || {or_last, or_data} !== held)) unstable++;
         if (or_valid && lat < 0) lat = c;
         stall = or_valid && !iw_ready;
         held = {or_last, or_data};
         if (or_valid && iw_ready) begin
            got.push_back(or_data);
            if (or_last) begin nlast++; last_pos = got.size() - 1; end
         end
         cyc();
         if (last_pos >= 0) break;
      end
      iw_ready = 1;
      ms = S_IDLE;
   endtask

   task automatic test_reset();
      iw_rst = 0;
      tick(); tick();
      checks++; if (or_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", or_state); end
      checks++; if (or_count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", or_count); end
      checks++; if ({or_valid, or_last} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {or_valid, or_last}); end
      checks++; if (or_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", or_data); end
      iw_rst = 1;
      tick();
   endtask

   task automatic test_trig_wrap();
      int lat, lp, nl, us, bad;
      clear(); arm(0);
      checks++; if (or_state !== 3'd1) begin failures++; $display("FAIL arm_state got=%0d exp=1", or_state); end
      for (int i = 0; i < 40; i++) begin
         sample(pat(i), 1, i == 30, 4'd5);
         checks++; if (or_state !== 3'(ms) || or_count !== 5'(q.size())) begin failures++; $display("FAIL wrap_track i=%0d got=%0d/%0d exp=%0d/%0d", i, or_state, or_count, ms, q.size()); end
         if (i == 34 || i == 35) begin
            checks++; if (or_state !== (i == 35 ? 3'd3 : 3'd2)) begin failures++; $display("FAIL wrap_done_edge i=%0d got=%0d", i, or_state); end
         end
      end
      checks++; if (or_count !== 5'd16) begin failures++; $display("FAIL wrap_count got=%0d exp=16", or_count); end
      readout(0, lat, lp, nl, us);
      checks++; if (lat !== 1) begin failures++; $display("FAIL read_latency got=%0d exp=1", lat); end
      bad = got.size() != 16;
      for (int i = 0; i < 16; i++) if (i < got.size() && got[i] !== pat(20 + i)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL wrap_data got=%0d entries bad=%0d exp=20..35", got.size(), bad); end
      checks++; if (lp !== 15 || nl !== 1) begin failures++; $display("FAIL wrap_last got=%0d/%0d exp=15/1", lp, nl); end
      checks++; if (or_state !== 3'd0 || or_valid !== 1'b0 || or_count !== 5'd16) begin failures++; $display("FAIL read_idle got=%0d/%b/%0d exp=0/0/16", or_state, or_valid, or_count); end
      iw_rd_start = 1; tick(); iw_rd_start = 0; tick();
      checks++; if (or_state !== 3'd0 || or_valid !== 1'b0) begin failures++; $display("FAIL idle_rd_start got=%0d/%b exp=0/0", or_state, or_valid); end
   endtask

   task automatic test_post_zero();
      int lat, lp, nl, us, bad;
      clear(); arm(0);
      for (int i = 1; i <= 4; i++) sample(pat(i), 1, i == 4, 4'd0);
      checks++; if (or_state !== 3'd3 || or_count !== 5'd4) begin failures++; $display("FAIL post0_done got=%0d/%0d exp=3/4", or_state, or_count); end
      readout(0, lat, lp, nl, us);
      bad = got.size() != 4;
      for (int i = 0; i < 4; i++) if (i < got.size() && got[i] !== pat(i + 1)) bad++;
      checks++; if (bad != 0 || lp !== 3) begin failures++; $display("FAIL post0_data got=%0d entries bad=%0d last=%0d exp=4/0/3", got.size(), bad, lp); end
   endtask

   task automatic test_single_fill();
      int lat, lp, nl, us, bad;
      clear(); arm(1);
      for (int i = 0; i < 20; i++) begin
         sample(pat(i), 1, 1'($urandom % 2), 4'($urandom));
         if (i == 14 || i == 15) begin
            checks++; if (or_state !== (i == 15 ? 3'd3 : 3'd1)) begin failures++; $display("FAIL fill_edge i=%0d got=%0d", i, or_state); end
         end
      end
      checks++; if (or_count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", or_count); end
      readout(0, lat, lp, nl, us);
      bad = got.size() != 16;
      for (int i = 0; i < 16; i++) if (i < got.size() && got[i] !== pat(i)) bad++;
      checks++; if (bad != 0 || lp !== 15) begin failures++; $display("FAIL fill_data got=%0d entries bad=%0d last=%0d exp=16/0/15", got.size(), bad, lp); end
   endtask

   task automatic test_abort_empty();
      clear(); arm(0);
      sample(16'hBEEF, 1, 1, 4'd0);
      iw_abort = 1; iw_rd_start = 1;
      tick();
      iw_abort = 0; iw_rd_start = 0;
      checks++; if (or_state !== 3'd0) begin failures++; $display("FAIL abort_rd_state got=%0d exp=0", or_state); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (or_valid !== 1'b0) begin failures++; $display("FAIL abort_rd_valid got=%b exp=0", or_valid); end
      end
      arm(0);
      sample(16'h1234, 0, 1, 4'd0);
      checks++; if (or_state !== 3'd3 || or_count !== 5'd0) begin failures++; $display("FAIL empty_done got=%0d/%0d exp=3/0", or_state, or_count); end
      iw_rd_start = 1; tick(); iw_rd_start = 0; tick();
      checks++; if (or_state !== 3'd3 || or_valid !== 1'b0) begin failures++; $display("FAIL empty_rd got=%0d/%b exp=3/0", or_state, or_valid); end
   endtask

   task automatic test_stall();
      int lat, lp, nl, us, bad;
      clear(); arm(0);
      for (int c = 0; c < 80 && ms != S_DONE; c++)
         sample(16'($urandom), $urandom % 3 != 0, c == 25, c == 25 ? 4'd4 : 4'($urandom));
      checks++; if (or_state !== 3'd3 || or_count !== 5'(q.size())) begin failures++; $display("FAIL stall_cap got=%0d/%0d exp=3/%0d", or_state, or_count, q.size()); end
      readout(1, lat, lp, nl, us);
      bad = got.size() != q.size();
      foreach (q[i]) if (i < got.size() && got[i] !== q[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL stall_data got=%0d entries bad=%0d exp=%0d", got.size(), bad, q.size()); end
      checks++; if (us != 0 || nl != 1) begin failures++; $display("FAIL stall_hold unstable=%0d lasts=%0d exp=0/1", us, nl); end
   endtask

   task automatic test_reset_mid();
      int lat, lp, nl, us, bad;
      clear(); arm(0);
      for (int i = 0; i < 8; i++) sample(pat(100 + i), 1, i == 3, 4'd10);
      checks++; if (or_state !== 3'd2) begin failures++; $display("FAIL rst_pre got=%0d exp=2", or_state); end
      iw_rst = 0; tick(); iw_rst = 1;
      checks++; if (or_state !== 3'd0 || or_count !== 5'd0) begin failures++; $display("FAIL rst_mid got=%0d/%0d exp=0/0", or_state, or_count); end
      checks++; if ({or_valid, or_last, or_data} !== 18'h0) begin failures++; $display("FAIL rst_mid_out got=%0h exp=0", {or_valid, or_last, or_data}); end
      arm(0);
      for (int i = 0; i < 8; i++) sample(pat(50 + i), 1, i == 5, 4'd2);
      checks++; if (or_state !== 3'd3 || or_count !== 5'd8) begin failures++; $display("FAIL rst_recap got=%0d/%0d exp=3/8", or_state, or_count); end
      readout(0, lat, lp, nl, us);
      bad = got.size() != 8;
      for (int i = 0; i < 8; i++) if (i < got.size() && got[i] !== pat(50 + i)) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rst_recap_data got=%0d entries bad=%0d exp=8", got.size(), bad); end
   endtask

   task automatic test_random();
      int lat, lp, nl, us, bad, ta;
      logic [3:0] pp;
      for (int n = 0; n < 8; n++) begin
         clear(); arm(1'($urandom % 2));
         ta = $urandom_range(0, 40);
         pp = 4'($urandom);
         for (int c = 0; c < 150 && ms != S_DONE; c++) begin
            sample(16'($urandom), $urandom % 4 != 0, c == ta, c == ta ? pp : 4'($urandom));
            checks++; if (or_state !== 3'(ms) || or_count !== 5'(q.size())) begin failures++; $display("FAIL rand_track n=%0d c=%0d got=%0d/%0d exp=%0d/%0d", n, c, or_state, or_count, ms, q.size()); end
         end
         if (ms == S_DONE && q.size() != 0) begin
            readout(2, lat, lp, nl, us);
            bad = got.size() != q.size();
            foreach (q[i]) if (i < got.size() && got[i] !== q[i]) bad++;
            checks++; if (bad != 0 || us != 0 || lp !== q.size() - 1) begin failures++; $display("FAIL rand_read n=%0d got=%0d entries bad=%0d unstable=%0d last=%0d exp=%0d", n, got.size(), bad, us, lp, q.size()); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_trig_wrap();
      test_post_zero();
      test_single_fill();
      test_abort_empty();
      test_stall();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/trace_buf.md
TRACE_BUF -- requirements
Module: trace_buf

Interface
REQ-001 SHALL have parameter P_CH, default 6, number of traced pipeline-stage channels.
REQ-002 SHALL have parameter P_W, default 24, bit width of each channel.
REQ-003 SHALL have parameter P_DEPTH, default 16, sample entries, power of two, >=4; AW = clog2(P_DEPTH).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 iw_clk  in  1  clock; all state changes on the rising edge.
REQ-006 iw_rst  in  1  synchronous active-low reset.
REQ-007 iw_data  in  P_CH*P_W  channel snapshot; channel k occupies bits [k*P_W +: P_W].
REQ-008 iw_valid  in  1  snapshot qualifier; a sample is written only when high.
REQ-009 iw_mode  in  1  0 = triggered capture, 1 = single-fill capture; sampled on arm.
REQ-010 iw_arm  in  1  start-capture pulse.
REQ-011 iw_trig  in  1  trigger event.
REQ-012 iw_post  in  AW  post-trigger sample count; sampled on trigger.
REQ-013 iw_abort  in  1  return to IDLE from any state.
REQ-014 iw_rd_start  in  1  begin readout.
REQ-015 iw_ready  in  1  consumer ready.
REQ-016 or_valid  out  1  readout entry valid.
REQ-017 or_data  out  P_CH*P_W  readout entry.
REQ-018 or_last  out  1  marks the final readout entry.
REQ-019 or_state  out  3  encoding IDLE=0, ARMED=1, POST=2, DONE=3, READ=4.
REQ-020 or_count  out  AW+1  number of stored entries, saturating at P_DEPTH.

Function
REQ-021 FSM states: IDLE, ARMED, POST, DONE, READ.
REQ-022 IDLE + iw_arm -> ARMED next cycle:
- write pointer and or_count cleared
- iw_mode latched
REQ-023 ARMED/POST + iw_valid:
- write iw_data at the write pointer
- pointer +1 modulo P_DEPTH (wrap overwrites the oldest entry)
- or_count +1, saturating at P_DEPTH
REQ-024 Mode 0, ARMED + iw_trig:
- the trigger-cycle sample is written if iw_valid
- iw_post is latched
- iw_post == 0 -> DONE; otherwise -> POST
REQ-025 POST: decrement the remaining count on each valid sample; on the sample that reaches zero -> DONE.
REQ-026 iw_trig is ignored outside ARMED, in mode 1, and in the arm cycle itself.
REQ-027 Mode 1, ARMED: -> DONE on the cycle the P_DEPTH-th sample is written; no wrap occurs.
REQ-028 DONE: buffer frozen; iw_valid ignored.
REQ-029 DONE + iw_rd_start:
- or_count == 0 -> request ignored, state stays DONE
- otherwise -> READ
REQ-030 DONE + iw_arm: re-arm exactly as REQ-022 (discards the capture).
REQ-031 READ order, oldest to newest:
- start index = write pointer if or_count == P_DEPTH, else 0
- or_count entries delivered
REQ-032 Read latency: or_valid rises 1 cycle after entering READ (registered memory read).
REQ-033 Handshake: transfer when or_valid && iw_ready; while or_valid && !iw_ready, or_data and or_last hold stable.
REQ-034 or_last high with the or_count-th entry; its transfer -> IDLE next cycle; or_valid low in IDLE.
REQ-035 iw_abort in any state -> IDLE next cycle; or_valid and or_last cleared; abort wins over simultaneous arm/trig/rd_start.
REQ-036 or_count and stored entries remain readable in IDLE after a completed readout until the next arm; a second readout requires a new capture.

Reset
REQ-037 While iw_rst is low at a clock edge:
- state IDLE
- write pointer, read pointer, post counter and or_count = 0
- or_valid = 0, or_last = 0, or_data = 0, iw_mode latch = 0
REQ-038 Reset mid-capture or mid-readout behaves identically to REQ-037; memory contents are not cleared and are not observable afterwards.

Verification (P_CH=2, P_W=8, P_DEPTH=16)
REQ-039 Mode 0, arm, valid samples 0..39, trig at sample 30, iw_post=5, iw_ready=1:
- DONE after sample 35
- or_count = 16
- readout 20..35 with or_last on 35.
REQ-040 Mode 0, 4 valid samples 1..4, trig on sample 4, iw_post=0 -> DONE; or_count = 4; readout 1,2,3,4.
REQ-041 Mode 1, arm, 20 samples -> DONE after the 16th; trig ignored; readout 0..15.
REQ-042 Readout with iw_ready toggling 1,0,0,1,... -> no duplicated or dropped entries; or_data held stable through stalls.
REQ-043 Abort and rd_start asserted together in DONE -> IDLE, no or_valid; trig with iw_valid=0 and iw_post=0 on an empty buffer -> DONE, or_count = 0, rd_start ignored.
REQ-044 iw_rst low during POST -> all REQ-037 values next cycle; a fresh arm/capture then succeeds.
